fb_write_ctrl: RTL and testbench
================================

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameter addr_bits, default 5, meaning frame-buffer address width (2^addr_bits pixels).
REQ-002 SHALL have parameter timeout_cycles, default 4096, meaning max clk cycles between bytes of one command.
REQ-003 SHALL have parameter bright_init, default 8'hFF, meaning brightness value after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  8  received UART byte.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 SHALL have port wr_addr  output  addr_bits  frame-buffer write address.
REQ-009 SHALL have port wr_data  output  24  write data, lanes {R,G,B}.
REQ-010 SHALL have port wr_byte_en  output  3  lane enables, bit2=R, bit1=G, bit0=B.
REQ-011 SHALL have port wr_en  output  1  one-cycle write strobe.
REQ-012 SHALL have port brightness  output  8  brightness setting for the scan/OE logic.
REQ-013 SHALL have port busy  output  1  high while a FILL sweep runs.
REQ-014 SHALL have port err  output  1  one-cycle protocol-error pulse.

Function
REQ-015 SHALL decode header byte as opcode=rx_data[7:5], addr=rx_data[addr_bits-1:0], accepted only in IDLE.
REQ-016 SHALL implement states IDLE, DATA (byte counter 0..2), FILL.
REQ-017 Opcode 000 WRITE_PIXEL SHALL expect 3 data bytes R,G,B; each written as it arrives, single-lane enable (R 100, G 010, B 001); after B, return to IDLE.
REQ-018 Opcodes 001/010/011 SHALL expect 1 data byte written to lane R/G/B respectively, then IDLE.
REQ-019 Opcode 100 FILL SHALL capture R,G,B with no writes, then sweep addresses 0..2^addr_bits-1, one write per cycle, wr_byte_en=111, wr_data={R,G,B}, busy high for exactly 2^addr_bits cycles, then IDLE.
REQ-020 Opcode 101 BRIGHT SHALL load 1 data byte into brightness, no RAM write, then IDLE.
REQ-021 Opcodes 110/111 SHALL pulse err one cycle after the byte, remain IDLE.
REQ-022 Single-lane writes SHALL drive wr_data={b,b,b} with wr_en high exactly the cycle after the data byte's rx_valid.
REQ-023 FILL sweep SHALL start the cycle after the B byte's rx_valid.
REQ-024 rx_valid during FILL SHALL be dropped with err pulse; sweep unaffected.
REQ-025 In DATA, cycles since last accepted byte reaching timeout_cycles SHALL return to IDLE with err pulse; lanes already written stay written.
REQ-026 Address arithmetic SHALL be modulo 2^addr_bits.
REQ-027 wr_en, err SHALL be low in all cycles not specified above.

Reset
REQ-028 rst low at a clock edge SHALL force IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_byte_en=0, busy=0, err=0, brightness=bright_init, timeout counter=0.
REQ-029 Reset mid-FILL or mid-command SHALL abort with no further writes.

Configuration
REQ-030 With FB_CTRL_AUTOINC_EN defined, WRITE_PIXEL after B SHALL increment address (wrapping 2^addr_bits-1 to 0) and stay in DATA expecting next R; timeout at byte counter 0 ends stream silently, mid-pixel timeout pulses err.
REQ-031 Without FB_CTRL_AUTOINC_EN, WRITE_PIXEL SHALL behave per REQ-017 only.

Verification
REQ-032 Bytes 0x41,0x20 -> one write addr 1, wr_data 0x202020, byte_en 010; no err.
REQ-033 Byte 0xC0 in IDLE -> err one cycle, no write, state IDLE.
REQ-034 Bytes 0x80,0x11,0x22,0x33 -> 32 consecutive writes addr 0..31, data 0x112233, en 111, busy 32 cycles; extra byte mid-sweep -> err, sweep completes.
REQ-035 Bytes 0x05,0xAA then idle timeout_cycles -> R write at addr 5, then err, next 0xA0,0x40 -> brightness 0x40.
REQ-036 With FB_CTRL_AUTOINC_EN: 0x1F then 6 data bytes -> writes addr 31 then addr 0; timeout at boundary -> no err.
REQ-037 rst low during FILL at addr 10 -> no writes after reset, brightness=0xFF, busy=0.

Source files
------------

// File: rtl/fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// FbWriteCtrl (module fb_write_ctrl)
//
// Purpose:
//   Decodes a byte stream from a UART receiver into frame-buffer writes for
//   an RGB LED panel. A header byte carries a 3-bit opcode in [7:5] and the
//   pixel address in [addr_bits-1:0]. Data bytes follow:
//     000 WRITE_PIXEL  R,G,B bytes, each written to its own lane on arrival
//     001/010/011      one byte written to the R/G/B lane
//     100 FILL         R,G,B captured, then every address written once
//     101 BRIGHT       one byte loaded into the brightness register
//     110/111          illegal, answered with an err pulse
//   A command that stalls for timeout_cycles between bytes is abandoned
//   with an err pulse.
//
// Configuration:
//   FB_CTRL_AUTOINC_EN  when defined, WRITE_PIXEL streams pixels: after the
//                       B byte the address advances (wrapping) and the next
//                       byte is taken as R of the following pixel. A timeout
//                       between pixels ends the stream without err; one
//                       inside a pixel still pulses err.
//
// Parameters:
//   addr_bits       frame-buffer address width (2^addr_bits pixels), 1..8
//   timeout_cycles  max clk cycles allowed between bytes of one command
//   bright_init     brightness value after reset
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-low reset
//   rx_data     received UART byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   wr_addr     frame-buffer write address
//   wr_data     write data, lanes {R,G,B}
//   wr_byte_en  lane enables, bit2=R, bit1=G, bit0=B
//   wr_en       one-cycle write strobe
//   brightness  brightness setting for the scan/OE logic
//   busy        high while a FILL sweep runs
//   err         one-cycle protocol-error pulse
// ---------------------------------------------------------------------------
module fb_write_ctrl #(
  parameter int         addr_bits      = 5,
  parameter int         timeout_cycles = 4096,
  parameter logic [7:0] bright_init    = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [addr_bits-1:0] wr_addr,
  output logic [23:0]          wr_data,
  output logic [2:0]           wr_byte_en,
  output logic                 wr_en,
  output logic [7:0]           brightness,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FILL
  } state_t;

  localparam logic [2:0] OP_PIXEL  = 3'b000;
  localparam logic [2:0] OP_RED    = 3'b001;
  localparam logic [2:0] OP_GREEN  = 3'b010;
  localparam logic [2:0] OP_BLUE   = 3'b011;
  localparam logic [2:0] OP_FILL   = 3'b100;
  localparam logic [2:0] OP_BRIGHT = 3'b101;

  localparam int                 TIMER_W    = $clog2(timeout_cycles + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(timeout_cycles - 1);

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [1:0]           byteCnt_q, byteCnt_d;
  logic [addr_bits-1:0] addr_q, addr_d;
  logic [7:0]           red_q, red_d;
  logic [7:0]           green_q, green_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           bright_q, bright_d;
  logic [addr_bits-1:0] wrAddr_q, wrAddr_d;
  logic [23:0]          wrData_q, wrData_d;
  logic [2:0]           wrByteEn_q, wrByteEn_d;
  logic                 wrEn_q, wrEn_d;
  logic                 err_q, err_d;
  logic                 silentEnd;

  // Lane index 0/1/2 maps to the R/G/B enable bit.
  function automatic logic [2:0] laneEnable(input logic [1:0] lane);
    case (lane)
      2'd0:    laneEnable = 3'b100;
      2'd1:    laneEnable = 3'b010;
      default: laneEnable = 3'b001;
    endcase
  endfunction

  // A timeout between streamed pixels is the normal end of a stream.
`ifdef FB_CTRL_AUTOINC_EN
  assign silentEnd = (op_q == OP_PIXEL) && (byteCnt_q == 2'd0);
`else
  assign silentEnd = 1'b0;
`endif

  // Command decoder. Every output is registered, so each effect shows up in
  // the cycle after the byte that caused it. The FILL sweep reuses the write
  // address register as its counter and ends after writing the last address.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    byteCnt_d  = byteCnt_q;
    addr_d     = addr_q;
    red_d      = red_q;
    green_d    = green_q;
    timer_d    = timer_q;
    bright_d   = bright_q;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    wrByteEn_d = wrByteEn_q;
    wrEn_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rx_valid) begin
          if (rx_data[7:6] == 2'b11) begin
            err_d = 1'b1;
          end else begin
            op_d      = rx_data[7:5];
            addr_d    = rx_data[addr_bits-1:0];
            byteCnt_d = 2'd0;
            state_d   = DATA;
          end
        end
      end

      DATA: begin
        if (rx_valid) begin
          timer_d   = '0;
          byteCnt_d = byteCnt_q + 2'd1;
          case (op_q)
            OP_PIXEL: begin
              wrEn_d     = 1'b1;
              wrAddr_d   = addr_q;
              wrData_d   = {3{rx_data}};
              wrByteEn_d = laneEnable(byteCnt_q);
              if (byteCnt_q == 2'd2) begin
`ifdef FB_CTRL_AUTOINC_EN
                addr_d    = addr_q + 1'b1;
                byteCnt_d = 2'd0;
`else
                state_d   = IDLE;
`endif
              end
            end
            OP_RED, OP_GREEN, OP_BLUE: begin
              wrEn_d     = 1'b1;
              wrAddr_d   = addr_q;
              wrData_d   = {3{rx_data}};
              wrByteEn_d = laneEnable(op_q[1:0] - 2'd1);
              state_d    = IDLE;
            end
            OP_FILL: begin
              case (byteCnt_q)
                2'd0:    red_d   = rx_data;
                2'd1:    green_d = rx_data;
                default: begin
                  wrEn_d     = 1'b1;
                  wrAddr_d   = '0;
                  wrData_d   = {red_q, green_q, rx_data};
                  wrByteEn_d = 3'b111;
                  state_d    = FILL;
                end
              endcase
            end
            OP_BRIGHT: begin
              bright_d = rx_data;
              state_d  = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          err_d   = !silentEnd;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      FILL: begin
        if (rx_valid) begin
          err_d = 1'b1;
        end
        if (&wrAddr_q) begin
          state_d = IDLE;
        end else begin
          wrEn_d   = 1'b1;
          wrAddr_d = wrAddr_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_PIXEL;
      byteCnt_q  <= 2'd0;
      addr_q     <= '0;
      red_q      <= 8'h00;
      green_q    <= 8'h00;
      timer_q    <= '0;
      bright_q   <= bright_init;
      wrAddr_q   <= '0;
      wrData_q   <= 24'h0;
      wrByteEn_q <= 3'b000;
      wrEn_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      byteCnt_q  <= byteCnt_d;
      addr_q     <= addr_d;
      red_q      <= red_d;
      green_q    <= green_d;
      timer_q    <= timer_d;
      bright_q   <= bright_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      wrByteEn_q <= wrByteEn_d;
      wrEn_q     <= wrEn_d;
      err_q      <= err_d;
    end
  end

  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign wr_byte_en = wrByteEn_q;
  assign wr_en      = wrEn_q;
  assign brightness = bright_q;
  assign busy       = (state_q == FILL);
  assign err        = err_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// TbFbWriteCtrl (module tb_fb_write_ctrl)
//
// Purpose:
//   Self-checking bench for fb_write_ctrl. A command-level model turns every
//   sampled input cycle into expected writes, errors, busy cycles and
//   brightness values keyed by cycle number; one compare process checks the
//   DUT against those every cycle. Directed sequences add literal checks.
//   Honours FB_CTRL_AUTOINC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fb_write_ctrl;

  localparam int AB   = 5;
  localparam int TO   = 20;
  localparam int NPIX = 1 << AB;
`ifdef FB_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [23:0]   data;
    logic [2:0]    en;
  } wr_t;

  typedef enum int {M_IDLE, M_CMD, M_FILL} mstate_t;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AB-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [2:0]    wr_byte_en;
  logic          wr_en;
  logic [7:0]    brightness;
  logic          busy;
  logic          err;

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;
  bit checkOn  = 1'b0;

  wr_t        expWr    [int];
  bit         expErr   [int];
  bit         expBusy  [int];
  logic [7:0] brightAt [int];
  logic [7:0] curBright = 8'hFF;

  fb_write_ctrl #(
    .addr_bits     (AB),
    .timeout_cycles(TO),
    .bright_init   (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_byte_en(wr_byte_en),
    .wr_en     (wr_en),
    .brightness(brightness),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Present one byte for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Command-level model: each edge's effect is recorded against the cycle
  // that follows it (the cycle number held in cyc after the edge).
  mstate_t    mState = M_IDLE;
  int         mOp, mAddr, mCnt, mLast, mFill;
  logic [7:0] mR, mG;
  logic [23:0] mFillData;

  function automatic wr_t laneWrite(input int addr, input int lane, input logic [7:0] d);
    wr_t w;
    w.addr = AB'(addr % NPIX);
    w.data = {d, d, d};
    w.en   = 3'b100 >> lane;
    return w;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst !== 1'b1) begin
      mState        = M_IDLE;
      brightAt[cyc] = 8'hFF;
    end else begin
      case (mState)
        M_IDLE: begin
          if (rx_valid) begin
            if (rx_data >= 8'hC0) begin
              expErr[cyc] = 1'b1;
            end else begin
              mOp    = int'(rx_data) / 32;
              mAddr  = int'(rx_data) % NPIX;
              mCnt   = 0;
              mLast  = cyc;
              mState = M_CMD;
            end
          end
        end
        M_CMD: begin
          if (rx_valid) begin
            mLast = cyc;
            if (mOp == 0) begin
              expWr[cyc] = laneWrite(mAddr, mCnt, rx_data);
              mCnt++;
              if (mCnt == 3) begin
                if (AUTOINC) begin
                  mAddr = (mAddr + 1) % NPIX;
                  mCnt  = 0;
                end else begin
                  mState = M_IDLE;
                end
              end
            end else if (mOp <= 3) begin
              expWr[cyc] = laneWrite(mAddr, mOp - 1, rx_data);
              mState     = M_IDLE;
            end else if (mOp == 4) begin
              if (mCnt == 0) mR = rx_data;
              else if (mCnt == 1) mG = rx_data;
              mCnt++;
              if (mCnt == 3) begin
                mFillData    = {mR, mG, rx_data};
                expWr[cyc]   = '{addr: '0, data: mFillData, en: 3'b111};
                expBusy[cyc] = 1'b1;
                mFill        = 1;
                mState       = M_FILL;
              end
            end else begin
              brightAt[cyc] = rx_data;
              mState        = M_IDLE;
            end
          end else if (cyc - mLast == TO) begin
            mState = M_IDLE;
            if (!(AUTOINC && mOp == 0 && mCnt == 0)) expErr[cyc] = 1'b1;
          end
        end
        default: begin
          if (rx_valid) expErr[cyc] = 1'b1;
          if (mFill == NPIX) begin
            mState = M_IDLE;
          end else begin
            expWr[cyc]   = '{addr: AB'(mFill), data: mFillData, en: 3'b111};
            expBusy[cyc] = 1'b1;
            mFill++;
          end
        end
      endcase
    end
  end

  // Compare process: DUT against the model on every cycle after reset.
  always @(negedge clk) begin
    if (checkOn) begin
      if (brightAt.exists(cyc)) curBright = brightAt[cyc];
      checkOutput("wr_en", 32'(wr_en), 32'(expWr.exists(cyc)));
      if (expWr.exists(cyc)) begin
        checkOutput("wr_addr", 32'(wr_addr), 32'(expWr[cyc].addr));
        checkOutput("wr_data", 32'(wr_data), 32'(expWr[cyc].data));
        checkOutput("wr_byte_en", 32'(wr_byte_en), 32'(expWr[cyc].en));
      end
      checkOutput("err", 32'(err), 32'(expErr.exists(cyc)));
      checkOutput("busy", 32'(busy), 32'(expBusy.exists(cyc)));
      checkOutput("brightness", 32'(brightness), 32'(curBright));
    end
  end

  initial begin
    int writes, busyCnt, errCnt, lastAddr, errAt, waitCnt;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idleCycles(2);
    #1;
    rst     = 1'b1;
    checkOn = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst wr_byte_en", 32'(wr_byte_en), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst brightness", 32'(brightness), 32'hFF);

    // Single green lane write
    applyStimulus(8'h41);
    applyStimulus(8'h20);
    @(negedge clk);
    checkOutput("green wr_en", 32'(wr_en), 32'd1);
    checkOutput("green wr_addr", 32'(wr_addr), 32'd1);
    checkOutput("green wr_data", 32'(wr_data), 32'h202020);
    checkOutput("green wr_byte_en", 32'(wr_byte_en), 32'b010);
    checkOutput("green err", 32'(err), 32'd0);

    // Illegal opcodes 110 and 111
    applyStimulus(8'hC0);
    @(negedge clk);
    checkOutput("op110 err", 32'(err), 32'd1);
    checkOutput("op110 wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    checkOutput("op110 err gone", 32'(err), 32'd0);
    applyStimulus(8'hE5);
    idleCycles(2);

    // Single red and blue lane writes
    applyStimulus(8'h3F);
    applyStimulus(8'h9C);
    applyStimulus(8'h7E);
    applyStimulus(8'h5A);
    @(negedge clk);
    checkOutput("blue wr_byte_en", 32'(wr_byte_en), 32'b001);
    checkOutput("blue wr_addr", 32'(wr_addr), 32'd30);

    // WRITE_PIXEL, then let any stream time out
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    @(negedge clk);
    checkOutput("pixel B data", 32'(wr_data), 32'h333333);
    idleCycles(TO + 3);

    // FILL sweep with a stray byte in the middle
    applyStimulus(8'h80);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    writes = 0; busyCnt = 0; errCnt = 0; lastAddr = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("fill first data", 32'(wr_data), 32'h112233);
      if (i == 5) begin
        rx_data  = 8'h55;
        rx_valid = 1'b1;
      end
      if (i == 6) rx_valid = 1'b0;
      if (wr_en) begin
        writes++;
        lastAddr = int'(wr_addr);
      end
      if (busy) busyCnt++;
      if (err) errCnt++;
    end
    checkOutput("fill writes", 32'(writes), 32'd32);
    checkOutput("fill busy cycles", 32'(busyCnt), 32'd32);
    checkOutput("fill last addr", 32'(lastAddr), 32'd31);
    checkOutput("fill stray err", 32'(errCnt), 32'd1);

    // Mid-command timeout, then brightness
    applyStimulus(8'h05);
    applyStimulus(8'hAA);
    @(negedge clk);
    checkOutput("timeout R addr", 32'(wr_addr), 32'd5);
    checkOutput("timeout R en", 32'(wr_byte_en), 32'b100);
    errAt = -1;
    for (int k = 1; k <= TO + 4; k++) begin
      @(negedge clk);
      if (err) errAt = k;
    end
    checkOutput("timeout err cycle", 32'(errAt), 32'(TO));
    applyStimulus(8'hA0);
    applyStimulus(8'h40);
    @(negedge clk);
    checkOutput("brightness load", 32'(brightness), 32'h40);

`ifdef FB_CTRL_AUTOINC_EN
    // Streaming pixels wrap 31 -> 0; the timeout between pixels is silent
    applyStimulus(8'h1F);
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h10 + i));
    @(negedge clk);
    checkOutput("autoinc wrap addr", 32'(wr_addr), 32'd0);
    errCnt = 0;
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge clk);
      if (err) errCnt++;
    end
    checkOutput("autoinc silent end", 32'(errCnt), 32'd0);
`endif

    // Reset in the middle of a FILL sweep
    applyStimulus(8'h80);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (!(wr_en && wr_addr == AB'(10)) && waitCnt < 64);
    checkOutput("reach addr 10", 32'(waitCnt < 64), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr_en) writes++;
      if (i == 0) begin
        checkOutput("rst fill busy", 32'(busy), 32'd0);
        checkOutput("rst fill brightness", 32'(brightness), 32'hFF);
      end
    end
    checkOutput("rst fill writes", 32'(writes), 32'd0);

    idleCycles(3);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
